// File: rtl/stereo_ram2vga.sv
// stereo_ram2vga: VGA scan-out engine that places two frame buffers (left and
// right eye) as windows on a raster.
//
// Two-stage pipeline, both stages advancing on the pixel enable pe:
//   stage A: window hit test, RAM read issue, sync/active decode
//   stage B: colour capture from RAM data, registered outputs
//
// Ports:
//   vclk, rst_n        system clock, asynchronous active-low reset
//   mode               0 both, 1 left only, 2 right only, 3 colour bars
//   data0/data1        left/right RAM read data
//   rdaddr0/rdaddr1    RAM read addresses
//   rden0/rden1        one-vclk read strobes
//   rdclk              RAM read clock (vclk)
//   hs, vs             active-low syncs
//   r, g, b, de        pixel colour and active-video flag
//   sof                one-vclk pulse at the pe of pixel (0,0)
//
// Optional feature: define STEREO_CROSSHAIR_EN to overlay a red crosshair on
// the centre row and column of each displayed window.
module stereo_ram2vga #(
  parameter int unsigned PIX_DIV = 4,
  parameter int unsigned H_ACT   = 640,
  parameter int unsigned H_FP    = 16,
  parameter int unsigned H_SYN   = 96,
  parameter int unsigned H_BP    = 48,
  parameter int unsigned V_ACT   = 480,
  parameter int unsigned V_FP    = 10,
  parameter int unsigned V_SYN   = 2,
  parameter int unsigned V_BP    = 33,
  parameter int unsigned DW      = 3,
  parameter int unsigned AW      = 16,
  parameter int unsigned WIN_W   = 200,
  parameter int unsigned WIN_H   = 200,
  parameter int unsigned WIN0_X  = 100,
  parameter int unsigned WIN1_X  = 340,
  parameter int unsigned WIN_Y   = 140,
  parameter int unsigned RD_LAT  = 1
) (
  input  logic          vclk,
  input  logic          rst_n,
  input  logic [1:0]    mode,
  input  logic [DW-1:0] data0,
  input  logic [DW-1:0] data1,
  output logic [AW-1:0] rdaddr0,
  output logic [AW-1:0] rdaddr1,
  output logic          rden0,
  output logic          rden1,
  output logic          rdclk,
  output logic          hs,
  output logic          vs,
  output logic [DW-1:0] r,
  output logic [DW-1:0] g,
  output logic [DW-1:0] b,
  output logic          de,
  output logic          sof
);

  localparam int unsigned H_TOT = H_ACT + H_FP + H_SYN + H_BP;
  localparam int unsigned V_TOT = V_ACT + V_FP + V_SYN + V_BP;
  localparam int unsigned XW    = $clog2(H_TOT);
  localparam int unsigned YW    = $clog2(V_TOT);
  localparam int unsigned DVW   = $clog2(PIX_DIV);

  // Source of the colour for the pixel travelling from stage A to stage B.
  typedef enum logic [1:0] {SelNone, SelCh0, SelCh1, SelBar} sel_e;

  logic [DVW-1:0] div_q;
  logic [XW-1:0]  x_q;
  logic [YW-1:0]  y_q;
  logic [1:0]     mode_q;
  logic [AW-1:0]  addr0_q, addr1_q;

  logic           pe, last_x, last_y, frame_start, clr_addr;
  logic [31:0]    xi, yi;
  logic           in_win0, in_win1, en0, en1, rd0, rd1;
  logic           active, hs_a, vs_a;
  sel_e           sel_a, sel_q;
  logic [DW-1:0]  bar_a, bar_q;
  logic           hs_p, vs_p, de_p;
  logic [DW-1:0]  pix_r, pix_gb;

  assign rdclk       = vclk;
  assign pe          = (div_q == DVW'(PIX_DIV - 1));
  assign xi          = 32'(x_q);
  assign yi          = 32'(y_q);
  assign last_x      = (xi == H_TOT - 1);
  assign last_y      = (yi == V_TOT - 1);
  assign frame_start = (xi == 0) && (yi == 0);
  assign clr_addr    = (xi == 0) && (yi == WIN_Y + WIN_H);

  always_ff @(posedge vclk or negedge rst_n) begin
    if (!rst_n) begin
      div_q  <= '0;
      x_q    <= '0;
      y_q    <= '0;
      mode_q <= 2'd0;
    end else begin
      div_q <= pe ? '0 : div_q + 1'b1;
      if (pe) begin
        if (last_x) begin
          x_q <= '0;
          y_q <= last_y ? '0 : y_q + 1'b1;
        end else begin
          x_q <= x_q + 1'b1;
        end
        if (frame_start) mode_q <= mode;
      end
    end
  end

  // Stage A decode.
  always_comb begin
    in_win0 = (xi >= WIN0_X) && (xi < WIN0_X + WIN_W) && (yi >= WIN_Y) && (yi < WIN_Y + WIN_H);
    in_win1 = (xi >= WIN1_X) && (xi < WIN1_X + WIN_W) && (yi >= WIN_Y) && (yi < WIN_Y + WIN_H);
    en0     = (mode_q == 2'd0) || (mode_q == 2'd1);
    en1     = (mode_q == 2'd0) || (mode_q == 2'd2);
    rd0     = in_win0 && en0;
    rd1     = in_win1 && en1;
    active  = (xi < H_ACT) && (yi < V_ACT);
    hs_a    = !((xi >= H_ACT + H_FP) && (xi < H_ACT + H_FP + H_SYN));
    vs_a    = !((yi >= V_ACT + V_FP) && (yi < V_ACT + V_FP + V_SYN));
    // Channel 0 wins on overlap; both channels still read.
    sel_a = SelNone;
    if (active) begin
      if (mode_q == 2'd3) sel_a = SelBar;
      else if (rd0)       sel_a = SelCh0;
      else if (rd1)       sel_a = SelCh1;
    end
    // Bar level is x[7:5], placed in the MSBs of the colour word.
    bar_a = '0;
    for (int i = 0; (i < int'(DW)) && (i < 3); i++) bar_a[int'(DW) - 1 - i] = xi[7 - i];
  end

`ifdef STEREO_CROSSHAIR_EN
  logic cross_a, cross_q;

  always_comb begin
    cross_a = 1'b0;
    if ((sel_a == SelCh0) && ((yi == WIN_Y + WIN_H / 2) || (xi == WIN0_X + WIN_W / 2)))
      cross_a = 1'b1;
    if ((sel_a == SelCh1) && ((yi == WIN_Y + WIN_H / 2) || (xi == WIN1_X + WIN_W / 2)))
      cross_a = 1'b1;
  end

  always_ff @(posedge vclk or negedge rst_n) begin
    if (!rst_n)  cross_q <= 1'b0;
    else if (pe) cross_q <= cross_a;
  end
`endif

  // Stage A registers: RAM reads, raster-linear window addresses, pipeline.
  always_ff @(posedge vclk or negedge rst_n) begin
    if (!rst_n) begin
      addr0_q <= '0;
      addr1_q <= '0;
      rdaddr0 <= '0;
      rdaddr1 <= '0;
      rden0   <= 1'b0;
      rden1   <= 1'b0;
      sel_q   <= SelNone;
      bar_q   <= '0;
      hs_p    <= 1'b1;
      vs_p    <= 1'b1;
      de_p    <= 1'b0;
    end else begin
      rden0 <= pe && rd0;
      rden1 <= pe && rd1;
      if (pe) begin
        if (rd0) rdaddr0 <= addr0_q;
        if (rd1) rdaddr1 <= addr1_q;
        if (clr_addr) begin
          addr0_q <= '0;
          addr1_q <= '0;
        end else begin
          if (rd0) addr0_q <= addr0_q + 1'b1;
          if (rd1) addr1_q <= addr1_q + 1'b1;
        end
        sel_q <= sel_a;
        bar_q <= bar_a;
        hs_p  <= hs_a;
        vs_p  <= vs_a;
        de_p  <= active;
      end
    end
  end

  // Stage B colour select; RD_LAT < PIX_DIV means RAM data is settled here.
  always_comb begin
    pix_r  = '0;
    pix_gb = '0;
    unique case (sel_q)
      SelCh0: begin pix_r = data0; pix_gb = data0; end
      SelCh1: begin pix_r = data1; pix_gb = data1; end
      SelBar: begin pix_r = bar_q; pix_gb = bar_q; end
      default: ;
    endcase
`ifdef STEREO_CROSSHAIR_EN
    if (cross_q) begin
      pix_r  = '1;
      pix_gb = '0;
    end
`endif
  end

  always_ff @(posedge vclk or negedge rst_n) begin
    if (!rst_n) begin
      hs  <= 1'b1;
      vs  <= 1'b1;
      de  <= 1'b0;
      r   <= '0;
      g   <= '0;
      b   <= '0;
      sof <= 1'b0;
    end else begin
      sof <= pe && frame_start;
      if (pe) begin
        hs <= hs_p;
        vs <= vs_p;
        de <= de_p;
        r  <= pix_r;
        g  <= pix_gb;
        b  <= pix_gb;
      end
    end
  end

endmodule

// File: tb/tb_stereo_ram2vga.sv
// Directed bench for stereo_ram2vga using a reduced raster so whole frames fit
// in a short run: 176 x 18 pixel frame, 2 vclk per pixel, 20x6 windows at
// x=10 and x=150 (the right one runs past the 160-pixel active width), y=3.
module tb_stereo_ram2vga;

  localparam int PD = 2;
  localparam int HT = 176;
  localparam int FRAME_CYC = HT * 18 * PD;

  logic       vclk = 1'b0;
  logic       rst_n;
  logic [1:0] mode;
  logic [2:0] data0 = '0, data1 = '0;
  logic [7:0] rdaddr0, rdaddr1;
  logic       rden0, rden1, rdclk, hs, vs, de, sof;
  logic [2:0] r, g, b;
  logic       const_data;

  int tests = 0;
  int fails = 0;
  int cur   = 0;
  int cyc;
  int n_rd0 = 0, n_rd1 = 0, n_hs = 0, n_vs = 0, n_de = 0;
  int s_rd0, s_rd1, s_hs, s_vs, s_de;
  logic [7:0] last0 = '0, last1 = '0;

  always #5 vclk = ~vclk;

  stereo_ram2vga #(
    .PIX_DIV(2), .H_ACT(160), .H_FP(4), .H_SYN(8), .H_BP(4),
    .V_ACT(12), .V_FP(2), .V_SYN(2), .V_BP(2),
    .DW(3), .AW(8), .WIN_W(20), .WIN_H(6),
    .WIN0_X(10), .WIN1_X(150), .WIN_Y(3), .RD_LAT(1)
  ) dut (
    .vclk(vclk), .rst_n(rst_n), .mode(mode), .data0(data0), .data1(data1),
    .rdaddr0(rdaddr0), .rdaddr1(rdaddr1), .rden0(rden0), .rden1(rden1),
    .rdclk(rdclk), .hs(hs), .vs(vs), .r(r), .g(g), .b(b), .de(de), .sof(sof)
  );

  // One-cycle-latency RAMs: constant data, or data derived from the address.
  always @(posedge vclk) begin
    if (rden0 === 1'b1) data0 <= const_data ? 3'd5 : rdaddr0[2:0];
    if (rden1 === 1'b1) data1 <= const_data ? 3'd2 : (rdaddr1[2:0] ^ 3'b111);
  end

  // Per-cycle activity counters; each posedge counts the cycle just ended.
  always @(posedge vclk) begin
    if (rden0 === 1'b1) begin n_rd0 <= n_rd0 + 1; last0 <= rdaddr0; end
    if (rden1 === 1'b1) begin n_rd1 <= n_rd1 + 1; last1 <= rdaddr1; end
    if (hs === 1'b0) n_hs <= n_hs + 1;
    if (vs === 1'b0) n_vs <= n_vs + 1;
    if (de === 1'b1) n_de <= n_de + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_rgb(input string tag, input int re, input int ge, input int be);
    check(tag, {23'd0, r, g, b}, {23'd0, 3'(re), 3'(ge), 3'(be)});
  endtask

  // Move to the sample point where the output for pixel (x,y) is displayed.
  task automatic at_pixel(input int x, input int y);
    int target;
    target = y * HT + x + 1;
    repeat ((target - cur) * PD) @(negedge vclk);
    cur = target;
  endtask

  task automatic wait_sof(input int limit, output int n);
    n = 0;
    do begin
      @(negedge vclk);
      n++;
    end while (sof !== 1'b1 && n < limit);
    cur = 0;
  endtask

  task automatic snap();
    s_rd0 = n_rd0; s_rd1 = n_rd1; s_hs = n_hs; s_vs = n_vs; s_de = n_de;
  endtask

  initial begin
    rst_n = 1'b1;
    mode = 2'd0;
    const_data = 1'b1;
    #3 rst_n = 1'b0;
    repeat (3) @(negedge vclk);
    check("rst_hs", hs, 1);
    check("rst_vs", vs, 1);
    check("rst_de", de, 0);
    check("rst_sof", sof, 0);
    check_rgb("rst_rgb", 0, 0, 0);
    check("rst_rden", {rden0, rden1}, 0);
    check("rst_rdaddr0", rdaddr0, 0);

    // First frame after release: sof one pixel period after release.
    @(negedge vclk);
    rst_n = 1'b1;
    wait_sof(20, cyc);
    check("sof_after_rst", cyc, PD);
    snap();

    // Frame 1: mode 0, constant RAM data.
    at_pixel(15, 4);   check_rgb("f1_win0", 5, 5, 5);
    at_pixel(100, 4);  check_rgb("f1_gap", 0, 0, 0);
    check("f1_gap_de", de, 1);
    at_pixel(155, 4);  check_rgb("f1_win1", 2, 2, 2);
    at_pixel(165, 4);  check_rgb("f1_win1_blank", 0, 0, 0);
    check("f1_blank_de", de, 0);
    at_pixel(164, 5);  check("f1_hs_first", hs, 0);
    at_pixel(163, 6);  check("f1_hs_before", hs, 1);
    at_pixel(0, 14);   check("f1_vs_first", vs, 0);
    check("f1_vblank_de", de, 0);
    wait_sof(FRAME_CYC, cyc);
    check("f1_sof", sof, 1);
    check("f1_rd0_cnt", n_rd0 - s_rd0, 120);
    check("f1_rd1_cnt", n_rd1 - s_rd1, 120);
    check("f1_last0", last0, 119);
    check("f1_last1", last1, 119);
    check("f1_hs_cyc", n_hs - s_hs, 8 * 18 * PD);
    check("f1_vs_cyc", n_vs - s_vs, 2 * HT * PD);
    check("f1_de_cyc", n_de - s_de, 160 * 12 * PD);
    snap();

    // Frame 2: address-derived data; switch to mode 1 mid-frame.
    const_data = 1'b0;
    at_pixel(12, 3);   check_rgb("f2_addr2", 2, 2, 2);
    at_pixel(17, 5);   check_rgb("f2_addr47", 7, 7, 7);
    at_pixel(100, 5);  mode = 2'd1;
    at_pixel(155, 8);  check_rgb("f2_addr105", 6, 6, 6);
    wait_sof(FRAME_CYC, cyc);
    check("f2_sof", sof, 1);
    check("f2_rd0_cnt", n_rd0 - s_rd0, 120);
    check("f2_rd1_cnt", n_rd1 - s_rd1, 120);
    check("f2_last1", last1, 119);
    snap();

    // Frame 3: mode 1 in effect.
    at_pixel(15, 4);   check_rgb("f3_addr25", 1, 1, 1);
    at_pixel(155, 4);  check_rgb("f3_win1_off", 0, 0, 0);
    mode = 2'd3;
    wait_sof(FRAME_CYC, cyc);
    check("f3_sof", sof, 1);
    check("f3_rd0_cnt", n_rd0 - s_rd0, 120);
    check("f3_rd1_cnt", n_rd1 - s_rd1, 0);
    snap();

    // Frame 4: colour bars.
    at_pixel(64, 2);   check_rgb("f4_bar64", 2, 2, 2);
    at_pixel(100, 2);  check_rgb("f4_bar100", 3, 3, 3);
    at_pixel(159, 2);  check_rgb("f4_bar159", 4, 4, 4);
    at_pixel(160, 2);  check_rgb("f4_bar_blank", 0, 0, 0);
    mode = 2'd0;
    const_data = 1'b1;
    wait_sof(FRAME_CYC, cyc);
    check("f4_sof", sof, 1);
    check("f4_rd_cnt", (n_rd0 - s_rd0) + (n_rd1 - s_rd1), 0);
    check("f4_hs_cyc", n_hs - s_hs, 8 * 18 * PD);
    check("f4_vs_cyc", n_vs - s_vs, 2 * HT * PD);

    // Frame 5: window centre, then asynchronous reset inside the window.
    at_pixel(20, 6);
`ifdef STEREO_CROSSHAIR_EN
    check_rgb("f5_cross", 7, 0, 0);
`else
    check_rgb("f5_centre", 5, 5, 5);
`endif
    at_pixel(21, 7);   check_rgb("f5_off_cross", 5, 5, 5);
    at_pixel(15, 8);   check_rgb("f5_pre_rst", 5, 5, 5);
    #1 rst_n = 1'b0;
    #1 check_rgb("f5_rst_rgb", 0, 0, 0);
    check("f5_rst_de", de, 0);
    @(negedge vclk);
    rst_n = 1'b1;
    wait_sof(20, cyc);
    check("f5_sof_after_rst", cyc, PD);

    // Frame 6: reset asserted while both syncs are low.
    at_pixel(166, 15);
    check("f6_pre_hs", hs, 0);
    check("f6_pre_vs", vs, 0);
    #1 rst_n = 1'b0;
    #1 check("f6_rst_hs", hs, 1);
    check("f6_rst_vs", vs, 1);
    @(negedge vclk);
    rst_n = 1'b1;
    wait_sof(20, cyc);
    check("f6_sof_after_rst", cyc, PD);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
